alu_result_buffer: RTL

Collects results from the ALU execution units (arithmetic/logic and shift) one cycle after each unit captures its operands, and queues them in a small FIFO for the downstream consumer using a valid/ready handshake. It tracks which unit was issued, selects that unit's output, and derives zero/negative flags. It drives a stall signal back to the issue logic so that no result is lost while the consumer applies backpressure.

---
 rtl/alu_result_buffer.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_result_buffer.sv
// Result collection stage for the ALU execution units: captures the issued unit's
// output one cycle after issue and queues it in a small FIFO toward the consumer.
module alu_result_buffer #(
  parameter int         DEPTH     = 4,
  parameter logic [2:0] SEL_ARITH = 3'b000,
  parameter logic [2:0] SEL_SHIFT = 3'b001
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [2:0]               alu_op_select,
  input  logic [31:0]              alu_arithmetic_out,
  input  logic [31:0]              alu_shift_out,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_zero,
  output logic                     out_negative,
  output logic                     alu_stall,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW:0]   STALL_AT = (CW+1)'(DEPTH);

  logic          pend_valid_q, pend_valid_d;
  logic [2:0]    pend_sel_q, pend_sel_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  logic [31:0]   mem_q [DEPTH];

  logic        issue, push, pop, overflow, wr_en;
  logic [31:0] res;

  always_comb begin
    issue    = enable & ((alu_op_select == SEL_ARITH) | (alu_op_select == SEL_SHIFT));
    res      = (pend_sel_q == SEL_ARITH) ? alu_arithmetic_out : alu_shift_out;
    push     = pend_valid_q;
    pop      = (count_q != '0) & out_ready;
    // A full FIFO with a concurrent pop still has room for the incoming result.
    overflow = push & (count_q == FULL) & ~pop;
    wr_en    = push & ~overflow;

    pend_valid_d = issue;
    pend_sel_d   = issue ? alu_op_select : pend_sel_q;
    wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr_en) count_d = count_q - CW'(1);
    drop_d = (overflow && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
      pend_sel_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= res;
  end

  always_comb begin
    out_data     = mem_q[rd_ptr_q];
    out_valid    = (count_q != '0);
    out_zero     = (out_data == 32'd0);
    out_negative = out_data[31];
    alu_stall    = ({1'b0, count_q} + {{CW{1'b0}}, pend_valid_q}) >= STALL_AT;
    fifo_count   = count_q;
    drop_count   = drop_q;
  end

endmodule
